// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input stimulus sweeper: holds each of 16 vectors for DWELL cycles and captures z into a truth table.
// Optional golden-table compare against EXPECTED is built only when SWEEP_CHECK_EN is defined.
module truth_table_sweeper #(
  parameter int          DWELL    = 100,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        z_i,
  output logic        a_o,
  output logic        b_o,
  output logic        c_o,
  output logic        d_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] table_o,
  output logic        fail_o,
  output logic [4:0]  err_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [15:0] LAST = 16'(DWELL - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] table_q, table_d;
  logic        sample;
  logic        clear;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 16'd0;
      table_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    sample  = 1'b0;
    clear   = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        vec_d = 4'd0;
        if (start_i) begin
          clear   = 1'b1;
          table_d = 16'h0000;
          cnt_d   = 16'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        cnt_d  = cnt_q + 16'd1;
        // Last cycle of the dwell: DUT has had DWELL-1 cycles to settle.
        if (cnt_q == LAST) begin
          sample         = 1'b1;
          cnt_d          = 16'd0;
          table_d[vec_q] = z_i;
          if (vec_q == 4'd15) state_d = S_FIN;
          else                vec_d   = vec_q + 4'd1;
        end
      end
      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
        vec_d   = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {a_o, b_o, c_o, d_o} = vec_q;
  assign table_o              = table_q;

`ifdef SWEEP_CHECK_EN
  logic [4:0] err_q, err_d;
  logic       fail_q, fail_d;

  always_comb begin
    err_d = err_q;
    if (clear)
      err_d = 5'd0;
    else if (sample && (z_i != EXPECTED[vec_q]) && (err_q != 5'd16))
      err_d = err_q + 5'd1;
    fail_d = (err_d != 5'd0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_q  <= 5'd0;
      fail_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      fail_q <= fail_d;
    end
  end

  assign err_cnt_o = err_q;
  assign fail_o    = fail_q;
`else
  logic unused_expected;
  assign unused_expected = ^{EXPECTED, sample};
  assign err_cnt_o       = 5'd0;
  assign fail_o          = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: DWELL=4 instance with selectable z, DWELL=2 instance with z=a&b|c&d.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [1:0]  zsel = 2'd0;
  logic        z1, z2;
  logic        a1, b1, c1, d1, busy1, done1, fail1;
  logic        a2, b2, c2, d2, busy2, done2, fail2;
  logic [15:0] tab1, tab2;
  logic [4:0]  err1, err2;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign z1 = (zsel == 2'd0) ? d1 : (zsel == 2'd1) ? a1 : ~d1;
  assign z2 = (a2 & b2) | (c2 & d2);

  truth_table_sweeper #(.DWELL(4), .EXPECTED(16'hAAAA)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .z_i(z1),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1),
    .busy_o(busy1), .done_o(done1), .table_o(tab1), .fail_o(fail1), .err_cnt_o(err1)
  );

  truth_table_sweeper #(.DWELL(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .z_i(z2),
    .a_o(a2), .b_o(b2), .c_o(c2), .d_o(d2),
    .busy_o(busy2), .done_o(done2), .table_o(tab2), .fail_o(fail2), .err_cnt_o(err2)
  );

  always @(negedge clk) if (done1) done_cnt++;

  function automatic logic [31:0] exp_err(input int n);
`ifdef SWEEP_CHECK_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Caller sets start=1 beforehand; returns one cycle into IDLE after FIN.
  task automatic run_sweep(input logic [15:0] exp_tab, input int n_err, input bit inject);
    tick();
    start = 1'b0;
    chk("cleared_table", {16'd0, tab1}, 32'h0);
    chk("busy_run", {31'd0, busy1}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("vector", {28'd0, a1, b1, c1, d1}, 32'(i));
      for (int j = 0; j < 4; j++) begin
        start = inject && ((4 * i + j) == 9 || (4 * i + j) == 63);
        tick();
      end
    end
    start = 1'b0;
    chk("fin_done", {31'd0, done1}, 32'd1);
    chk("fin_busy", {31'd0, busy1}, 32'd0);
    chk("fin_vec", {28'd0, a1, b1, c1, d1}, 32'hF);
    chk("fin_table", {16'd0, tab1}, {16'd0, exp_tab});
    chk("fin_err", {27'd0, err1}, exp_err(n_err));
    chk("fin_fail", {31'd0, fail1}, (exp_err(n_err) != 0) ? 32'd1 : 32'd0);
    tick();
    chk("idle_done", {31'd0, done1}, 32'd0);
    chk("idle_vec", {28'd0, a1, b1, c1, d1}, 32'h0);
    chk("idle_table_hold", {16'd0, tab1}, {16'd0, exp_tab});
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_table", {16'd0, tab1}, 32'h0);
    chk("rst_vec", {28'd0, a1, b1, c1, d1}, 32'h0);
    chk("rst_err", {27'd0, err1}, 32'd0);
    chk("rst_fail", {31'd0, fail1}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", {31'd0, busy1}, 32'd0);

    // z=d with stray starts at cycles 10 and 64
    zsel  = 2'd0;
    start = 1'b1;
    run_sweep(16'hAAAA, 0, 1'b1);
    chk("done_once", 32'(done_cnt), 32'd1);

    // Back-to-back with z=~d: all 16 mismatch, count saturates
    zsel  = 2'd2;
    start = 1'b1;
    run_sweep(16'h5555, 16, 1'b0);

    // z=a
    zsel  = 2'd1;
    start = 1'b1;
    run_sweep(16'hFF00, 8, 1'b0);

    // Reset during vector 7
    zsel  = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    chk("mid_vec7", {28'd0, a1, b1, c1, d1}, 32'd7);
    chk("mid_table", {16'd0, tab1}, 32'h002A);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_vec", {28'd0, a1, b1, c1, d1}, 32'h0);
    chk("mrst_busy", {31'd0, busy1}, 32'd0);
    chk("mrst_table", {16'd0, tab1}, 32'h0);
    chk("mrst_err", {27'd0, err1}, 32'd0);
    tick();
    chk("mrst_idle", {31'd0, busy1}, 32'd0);
    start = 1'b1;
    run_sweep(16'hAAAA, 0, 1'b0);
    chk("done_total", 32'(done_cnt), 32'd4);

    // Minimum dwell instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (31) tick();
    chk("d2_busy_last", {31'd0, busy2}, 32'd1);
    chk("d2_vec_last", {28'd0, a2, b2, c2, d2}, 32'hF);
    tick();
    chk("d2_done", {31'd0, done2}, 32'd1);
    chk("d2_busy_fin", {31'd0, busy2}, 32'd0);
    chk("d2_table", {16'd0, tab2}, 32'hF888);
    chk("d2_err", {27'd0, err2}, exp_err(7));
    tick();
    chk("d2_done_low", {31'd0, done2}, 32'd0);
    chk("d2_idle_vec", {28'd0, a2, b2, c2, d2}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Self-checking stimulus and capture stage for 4-input combinational function blocks. It drives a DUT's `a,b,c,d` inputs through all 16 combinations in ascending order and holds each combination for a programmable dwell time. At the end of each dwell it samples the DUT output `z` into a 16-bit truth-table register. It sits directly upstream of, and feeds, a minimized-function block, replacing hand-written exhaustive stimulus with a reusable, restartable sweep.

## Interface
- `DWELL`, default 100: clock cycles each input vector is held; legal range 2..65535.
- `EXPECTED`, default 16'h0000: golden truth table; bit i is the required `z` for vector i = {a,b,c,d}.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `a`  out  1  vector bit 3 (MSB).
- `b`  out  1  vector bit 2.
- `c`  out  1  vector bit 1.
- `d`  out  1  vector bit 0 (LSB).
- `z`  in  1  DUT response.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `table`  out  16  captured truth table; bit i = `z` sampled for vector i.
- `fail`  out  1  any mismatch against `EXPECTED` (see Configuration).
- `err_cnt`  out  5  mismatch count, 0..16 (see Configuration).

## Operation
- State machine: IDLE, RUN, FIN.
- Reset, taken on any edge where `rst_n`=0, including mid-sweep:
  - state goes to IDLE;
  - vec=0, so `a,b,c,d`=0;
  - dwell counter=0;
  - `busy`=0, `done`=0, `table`=16'h0000, `fail`=0, `err_cnt`=0.
- IDLE:
  - `a..d`=0.
  - `start`=1 clears `table`, `err_cnt` and `fail`, sets vec=0 and cnt=0, and moves to RUN.
- RUN:
  - `{a,b,c,d}`=vec; `busy`=1.
  - cnt increments each edge.
  - When cnt==DWELL-1: `table[vec]`<=`z` and cnt<=0.
    - If vec==15, go to FIN.
    - Otherwise vec<=vec+1.
- FIN:
  - `done`=1 and `busy`=0; `a..d` still show 4'hF.
  - Next edge goes to IDLE unconditionally.
- `start` is ignored in RUN and FIN; no restart or queueing.
- `table` holds its value after the sweep until the next accepted `start` or reset.
- The counter is 16 bits wide. vec is 4 bits wide and never wraps past 15 within a sweep.

## Timing
- Let E0 be the edge at which `start` is accepted.
  - vector 0 appears after E0.
  - vector i is driven for exactly DWELL cycles, from edge E0+i·DWELL to edge E0+(i+1)·DWELL.
- `z` for vector i is sampled on edge E0+(i+1)·DWELL, the last edge before the vector changes. The DUT therefore gets DWELL-1 full cycles to settle.
- `done` is high for the single cycle following edge E0+16·DWELL.
- The sweep occupies 16·DWELL+1 cycles from E0 back to IDLE.
- `busy` rises after E0 and falls after edge E0+16·DWELL.
- A new `start` is accepted at the earliest on the edge ending the FIN cycle, i.e. with the machine back in IDLE: edge E0+16·DWELL+2.
- `table` bit i is updated on its sample edge. Intermediate values are visible but only valid once `done` pulses.

## Configuration
- `SWEEP_CHECK_EN` defined:
  - on each sample edge, if `z` != `EXPECTED[vec]`, `err_cnt` increments (saturates at 16, which cannot be exceeded).
  - `fail` = (`err_cnt` != 0), registered.
  - Both are valid at `done` and hold until the next `start` or reset.
- `SWEEP_CHECK_EN` undefined:
  - no comparison logic is built;
  - `fail` and `err_cnt` are constant 0;
  - `EXPECTED` is unused.

## Test plan
- DWELL=4, `z`=`d`, EXPECTED=16'hAAAA, pulse `start` -> vectors 0..15 each held 4 cycles; `done` pulses in the cycle following edge E0+64 (observed high at edge E0+65); `table`=16'hAAAA; `fail`=0; `err_cnt`=0.
- DWELL=4, `z`=`a`, EXPECTED=16'hAAAA (macro on) -> `table`=16'hFF00, `err_cnt`=8, `fail`=1; with the macro off, `fail`=0 and `err_cnt`=0.
- DWELL=2 (minimum), `z`=`a&b | c&d` -> `table`=16'hF888; sweep returns to IDLE 33 cycles after E0.
- `start` reasserted at cycles 10 and 64 of a DWELL=4 sweep -> ignored; exactly one `done`; vector sequence unchanged.
- `rst_n`=0 for one cycle during vector 7 -> next cycle `a..d`=0, `busy`=0, `table`=0, `err_cnt`=0, state IDLE; a subsequent `start` yields a full correct sweep.
- Back-to-back sweeps: `start` at the first IDLE edge after `done`, with `z` changed from `d` to `~d` -> second `table`=16'h5555, with no residue from the first sweep.
